// File: rtl/sync_flop_bank_pkg.sv
// Shared definitions for sync_flop_bank: the bank-wide flip-flop mode
// encoding and the single-channel next-state function.
package vaman_flop_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } flop_mode_e;

  // Next state of one channel for the given mode and synchronised inputs.
  // sr_both_reset selects what SR does on S=R=1: hold (0) or clear (1).
  function automatic logic next_q(input flop_mode_e mode,
                                  input logic       a,
                                  input logic       b,
                                  input logic       q,
                                  input logic       sr_both_reset);
    logic n;
    n = q;
    case (mode)
      MODE_SR: begin
        case ({a, b})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11:   n = sr_both_reset ? 1'b0 : q;
          default: n = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b10:   n = 1'b1;
          2'b01:   n = 1'b0;
          2'b11:   n = ~q;
          default: n = q;
        endcase
      end
      MODE_D:  n = a;
      MODE_T:  n = a ? ~q : q;
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sync_flop_bank_tick_gen.sv
// Tick divider for sync_flop_bank.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : one-cycle pulse every DIV clk cycles (registered)
//   blink : heartbeat, inverts on every edge where tick is high
module tick_gen #(
  parameter int unsigned DIV = 30000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick,
  output logic blink
);

  localparam int unsigned      CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]    LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;
  logic          r_blink;
  logic          w_wrap;

  assign w_wrap = (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_blink <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CW'(1);
      // Registered wrap: tick is high in the cycle after the counter
      // reaches DIV-1, so the first tick follows DIV edges after reset.
      r_tick <= w_wrap;
      if (r_tick) begin
        r_blink <= ~r_blink;
      end
    end
  end

  assign tick  = r_tick;
  assign blink = r_blink;

endmodule

// File: rtl/sync_flop_bank.sv
// Bank of CHANNELS runtime-configurable flip-flops (SR/JK/D/T) updated
// only on divider ticks.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   mode     : bank mode (0 SR, 1 JK, 2 D, 3 T), quasi-static, sampled at tick
//   a, b     : per-channel asynchronous inputs (S/J/D/T, R/K/-/-)
//   q        : per-channel registered state
//   tick     : one-cycle update pulse
//   blink    : heartbeat toggling on each tick
//   conflict : sticky per-channel flag, S=R=1 seen at a tick in SR mode
module sync_flop_bank
  import vaman_flop_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned DIV           = 30000000,
  parameter bit          SR_BOTH_RESET = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] q,
  output logic                tick,
  output logic                blink,
  output logic [CHANNELS-1:0] conflict
);

  logic [CHANNELS-1:0] r_a_s1, r_a_s2;
  logic [CHANNELS-1:0] r_b_s1, r_b_s2;
  logic                w_tick;
  logic                w_blink;
  flop_mode_e          w_mode;

  assign w_mode = flop_mode_e'(mode);

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .blink (w_blink)
  );

  // Two-flop synchronisers: a value is used at a tick only if it was on
  // the pins at the edge two before the update edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_s1 <= '0;
      r_a_s2 <= '0;
      r_b_s1 <= '0;
      r_b_s2 <= '0;
    end else begin
      r_a_s1 <= a;
      r_a_s2 <= r_a_s1;
      r_b_s1 <= b;
      r_b_s2 <= r_b_s1;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic r_q;
    logic r_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q        <= 1'b0;
        r_conflict <= 1'b0;
      end else if (w_tick) begin
        r_q <= next_q(w_mode, r_a_s2[i], r_b_s2[i], r_q, SR_BOTH_RESET);
        if (w_mode == MODE_SR && r_a_s2[i] && r_b_s2[i]) begin
          r_conflict <= 1'b1;
        end
      end
    end

    assign q[i]        = r_q;
    assign conflict[i] = r_conflict;
  end

  assign tick  = w_tick;
  assign blink = w_blink;

endmodule

// File: tb/tb_sync_flop_bank.sv
// Scoreboard bench for sync_flop_bank: two instances (SR_BOTH_RESET 0/1)
// share stimulus; expected post-tick state is queued by the stimulus and
// checked by a monitor on each update edge.
module tb_sync_flop_bank;
  import vaman_flop_pkg::*;

  localparam int unsigned DIV = 4;
  localparam int unsigned CH  = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [1:0]    mode  = 2'b00;
  logic [CH-1:0] a     = '0;
  logic [CH-1:0] b     = '0;

  logic [CH-1:0] q0, q1, cf0, cf1;
  logic          tk0, tk1, bl0, bl1;

  typedef struct packed {
    logic [1:0] dq0;
    logic [1:0] dq1;
    logic [1:0] dc0;
    logic [1:0] dc1;
    logic       bl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic exp_blink = 1'b0;

  always #5 clk = ~clk;

  sync_flop_bank #(
    .CHANNELS      (CH),
    .DIV           (DIV),
    .SR_BOTH_RESET (1'b0)
  ) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .q        (q0),
    .tick     (tk0),
    .blink    (bl0),
    .conflict (cf0)
  );

  sync_flop_bank #(
    .CHANNELS      (CH),
    .DIV           (DIV),
    .SR_BOTH_RESET (1'b1)
  ) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .a        (a),
    .b        (b),
    .q        (q1),
    .tick     (tk1),
    .blink    (bl1),
    .conflict (cf1)
  );

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_q0", q0, 2'b00);
    chk("rst_q1", q1, 2'b00);
    chk("rst_cf0", cf0, 2'b00);
    chk("rst_cf1", cf1, 2'b00);
    chk("rst_tick0", {1'b0, tk0}, 2'b00);
    chk("rst_tick1", {1'b0, tk1}, 2'b00);
    chk("rst_blink0", {1'b0, bl0}, 2'b00);
    chk("rst_blink1", {1'b0, bl1}, 2'b00);
  endtask

  // One tick period. Called just after an update edge (or just after the
  // first edge following reset release). Slot k of as/bs is driven just
  // after the k-th following edge; the next update samples slot 1.
  task automatic period(input logic [1:0] m, input logic [7:0] as, input logic [7:0] bs,
                        input logic [1:0] eq0, input logic [1:0] eq1,
                        input logic [1:0] ec0, input logic [1:0] ec1);
    exp_t e;
    exp_blink = ~exp_blink;
    e.dq0 = eq0;
    e.dq1 = eq1;
    e.dc0 = ec0;
    e.dc1 = ec1;
    e.bl  = exp_blink;
    sb.push_back(e);
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin
        @(posedge clk);
        #1;
      end
      mode = m;
      a    = as[2*k +: 2];
      b    = bs[2*k +: 2];
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: tick timing, q hold between ticks, scoreboard pop after ticks.
  initial begin : monitor
    int         since;
    logic       prev_tick;
    logic       exp_tick;
    logic [1:0] pq0;
    logic [1:0] pq1;
    exp_t       e;
    since     = 0;
    prev_tick = 1'b0;
    pq0       = '0;
    pq1       = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        since     = 0;
        prev_tick = 1'b0;
        pq0       = '0;
        pq1       = '0;
      end else begin
        since++;
        if (prev_tick) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: update seen with no expected entry at %0t", $time);
          end else begin
            e = sb.pop_front();
            chk("q0", q0, e.dq0);
            chk("q1", q1, e.dq1);
            chk("conflict0", cf0, e.dc0);
            chk("conflict1", cf1, e.dc1);
            chk("blink0", {1'b0, bl0}, {1'b0, e.bl});
            chk("blink1", {1'b0, bl1}, {1'b0, e.bl});
          end
        end else begin
          chk("q0_hold", q0, pq0);
          chk("q1_hold", q1, pq1);
        end
        exp_tick = ((since % DIV) == 0);
        chk("tick0", {1'b0, tk0}, {1'b0, exp_tick});
        chk("tick1", {1'b0, tk1}, {1'b0, exp_tick});
        prev_tick = tk0;
        pq0       = q0;
        pq1       = q1;
      end
    end
  end

  initial begin : stimulus
    #1 rst_n = 1'b0;
    #1 chk_reset_outputs();
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     mode     a slots 3..0   b slots 3..0   q0     q1     cf0    cf1
    period(MODE_SR, 8'b00_00_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 2'b00, 2'b00);
    period(MODE_SR, 8'b01_01_01_01, 8'b10_10_10_10, 2'b01, 2'b01, 2'b00, 2'b00);
    period(MODE_SR, 8'b11_11_11_11, 8'b11_11_11_11, 2'b01, 2'b00, 2'b11, 2'b11);
    period(MODE_D,  8'b00_00_00_00, 8'b11_11_11_11, 2'b00, 2'b00, 2'b11, 2'b11);
    period(MODE_JK, 8'b11_11_11_11, 8'b11_11_11_11, 2'b11, 2'b11, 2'b11, 2'b11);
    period(MODE_JK, 8'b11_11_11_11, 8'b11_11_11_11, 2'b00, 2'b00, 2'b11, 2'b11);
    period(MODE_JK, 8'b11_11_11_11, 8'b11_11_11_11, 2'b11, 2'b11, 2'b11, 2'b11);
    period(MODE_T,  8'b10_10_10_10, 8'b11_11_11_11, 2'b01, 2'b01, 2'b11, 2'b11);
    period(MODE_T,  8'b10_10_10_10, 8'b11_11_11_11, 2'b11, 2'b11, 2'b11, 2'b11);
    period(MODE_D,  8'b00_00_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 2'b11, 2'b11);
    // a rises one cycle before tick: missed, then taken at the next tick
    period(MODE_D,  8'b11_11_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 2'b11, 2'b11);
    period(MODE_D,  8'b11_11_11_11, 8'b00_00_00_00, 2'b11, 2'b11, 2'b11, 2'b11);
    period(MODE_D,  8'b00_00_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 2'b11, 2'b11);
    // a rises two cycles before tick: captured
    period(MODE_D,  8'b11_11_11_00, 8'b00_00_00_00, 2'b11, 2'b11, 2'b11, 2'b11);
    // inputs toggle every cycle; only slot 1 reaches the update
    period(MODE_D,  8'b11_10_01_11, 8'b00_01_10_11, 2'b01, 2'b01, 2'b11, 2'b11);
    period(MODE_SR, 8'b01_11_10_01, 8'b10_11_01_10, 2'b10, 2'b10, 2'b11, 2'b11);
    period(MODE_SR, 8'b11_11_11_11, 8'b00_00_00_00, 2'b11, 2'b11, 2'b11, 2'b11);

    // Asynchronous reset with counter at 2, away from any clock edge
    @(posedge clk);
    #4 rst_n = 1'b0;
    #1 chk_reset_outputs();
    a = '0;
    b = '0;
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_blink = 1'b0;

    period(MODE_SR, 8'b00_00_00_00, 8'b00_00_00_00, 2'b00, 2'b00, 2'b00, 2'b00);
    period(MODE_SR, 8'b10_10_10_10, 8'b00_00_00_00, 2'b10, 2'b10, 2'b00, 2'b00);
    period(MODE_JK, 8'b11_11_11_11, 8'b11_11_11_11, 2'b01, 2'b01, 2'b00, 2'b00);

    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected updates never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_flop_bank.md
# sync_flop_bank

Parametrised bank of CHANNELS independent storage elements clocked by an internal tick divider, replacing the single SR element on a divided LED-rate clock. Each channel synchronises its two control inputs into the system clock domain and updates its output only on a divider tick, using one of four runtime-selectable flip-flop modes (SR, JK, D, T). Sits between board switches/GPIO and the LEDs on the FPGA fabric, fully synchronous to `clk` (sourced from Sys_Clk0).

## Interface
- CHANNELS, default 4: number of independent channels (1..32).
- DIV, default 30000000: tick period in `clk` cycles (>= 2).
- SR_BOTH_RESET, default 0: SR mode with S=R=1; 0 = hold, 1 = clear to 0.

- clk  input  1  system clock (Sys_Clk0).
- rst_n  input  1  asynchronous active-low reset.
- mode  input  2  per-bank mode: 0 SR, 1 JK, 2 D, 3 T.
- a  input  CHANNELS  per-channel primary input (S / J / D / T), asynchronous.
- b  input  CHANNELS  per-channel secondary input (R / K / unused / unused), asynchronous.
- q  output  CHANNELS  channel state, registered.
- tick  output  1  one-cycle pulse marking each update edge.
- blink  output  1  toggles on every tick (visible heartbeat, 50% duty).
- conflict  output  CHANNELS  sticky flag per channel: S=R=1 sampled in SR mode.

## Operation
- `a`, `b` each pass through a 2-flop synchroniser; `mode` is sampled unsynchronised at tick (treated as quasi-static).
- Divider counter, width $clog2(DIV), counts 0..DIV-1 and wraps to 0; `tick` registered, high for exactly one cycle when counter wraps.
- On a `clk` edge with `tick`=1, each channel i computes next q from synchronised a_s[i], b_s[i]:
  - SR: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> hold (SR_BOTH_RESET=0) or 0 (=1), and sets conflict[i].
  - JK: 10 -> 1; 01 -> 0; 00 -> hold; 11 -> toggle.
  - D: q <= a_s; b ignored.
  - T: a_s=1 -> toggle; else hold; b ignored.
- Between ticks q holds regardless of input activity.
- `blink` inverts on each tick edge.
- `conflict[i]` clears only on reset; not set in JK/D/T modes.
- Mode change takes effect at the next tick; no state is cleared on a mode change.

## Timing
- Reset (rst_n low, asynchronous): q=0, tick=0, blink=0, conflict=0, counter=0, synchronisers=0. Release is synchronous in effect: first tick occurs DIV cycles after the first clk edge with rst_n high.
- Tick spacing exactly DIV cycles; first tick high in cycle DIV after reset release (counter reaches DIV-1, tick registered).
- Input-to-sample latency: an input edge must be present at the pins >= 2 clk edges before the tick edge to be used at that tick; inputs held for < 2 cycles before tick use the old value.
- q, blink, conflict change on the clk edge where tick=1; visible the same cycle tick deasserts.
- Reset asserted mid-period aborts the count; no partial tick is generated.
- All channels update on the same edge; no inter-channel ordering.

## Structure
- Package `vaman_flop_pkg`: enum `flop_mode_e` {MODE_SR=0, MODE_JK=1, MODE_D=2, MODE_T=3}; a function `next_q(mode, a, b, q, sr_both_reset)` shared with the bench model.
- Sub-module `tick_gen` (params DIV; ports clk, rst_n, tick, blink): counter, tick pulse, heartbeat.
- Top contains synchronisers, per-channel generate loop for q/conflict.

## Test plan
- Reset/period: DIV=4, CHANNELS=2; release rst_n -> first tick at cycle 4, then every 4 cycles; blink toggles each tick; q=0, conflict=0 throughout with a=b=0.
- SR mode: a=2'b01, b=2'b10 stable -> after next tick q=2'b01; then a=b=2'b11 -> q holds 2'b01 (SR_BOTH_RESET=0), conflict=2'b11; rerun with SR_BOTH_RESET=1 -> q=2'b00.
- JK/T toggle: mode=JK, a=b=2'b11 -> q alternates 00,11,00 over three ticks; mode=T, a=2'b10 -> only q[1] toggles per tick.
- D mode and setup window: mode=D, change a from 0 to 1 one cycle before tick -> q stays 0 at that tick, becomes 1 at the following tick; change 2 cycles before -> captured at that tick.
- Between-tick isolation: toggle a/b every cycle between ticks, stable at tick -> q reflects only the values stable for 2 cycles before tick.
- Reset mid-operation: q=2'b11, conflict set, counter at 2; pulse rst_n low asynchronously (not on a clk edge) -> all outputs 0 immediately; next tick exactly DIV cycles after release.
